// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one registered W-bit adder among NREQ requesters.
// Three cycles per op (IDLE capture, EXEC add, DONE ack); requesters hold req until their one-cycle ack.
module adder_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int SAT  = 0,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   op_a,
    input  logic [NREQ*W-1:0]   op_b,
    output logic [NREQ-1:0]     ack,
    output logic                res_valid,
    output logic [IDW-1:0]      res_id,
    output logic [W-1:0]        res_sum,
    output logic                res_carry,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] win_id;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W:0]     add_full;
    logic           grant_vld;
    logic [IDW-1:0] grant_id;
    int             idx;

    // Walk offsets from the highest down so the lowest offset from rr_ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) begin
                grant_vld = 1'b1;
                grant_id  = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = EXEC;
            EXEC:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    assign add_full = {1'b0, a_q} + {1'b0, b_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            win_id    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_id    <= '0;
            res_sum   <= '0;
            res_carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        a_q    <= op_a[int'(grant_id)*W +: W];
                        b_q    <= op_b[int'(grant_id)*W +: W];
                        win_id <= grant_id;
                    end
                end
                EXEC: begin
                    res_carry <= add_full[W];
                    res_sum   <= (SAT != 0 && add_full[W]) ? {W{1'b1}} : add_full[W-1:0];
                    res_id    <= win_id;
                end
                DONE: begin
                    rr_ptr <= (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
                end
                default: ;
            endcase
        end
    end

    // res_* are loaded on the way into DONE, so they hold steady outside it.
    assign res_valid = (state == DONE);
    assign ack       = res_valid ? (NREQ'(1) << res_id) : '0;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter: wrap and saturating instances share all inputs.
module tb_adder_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  ack, ack_s;
    logic        res_valid, res_valid_s;
    logic [1:0]  res_id, res_id_s;
    logic [7:0]  res_sum, res_sum_s;
    logic        res_carry, res_carry_s;
    logic        busy, busy_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adder_rr_arbiter #(.NREQ(4), .W(8), .SAT(0)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
        .ack(ack), .res_valid(res_valid), .res_id(res_id),
        .res_sum(res_sum), .res_carry(res_carry), .busy(busy)
    );

    adder_rr_arbiter #(.NREQ(4), .W(8), .SAT(1)) dut_sat (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
        .ack(ack_s), .res_valid(res_valid_s), .res_id(res_id_s),
        .res_sum(res_sum_s), .res_carry(res_carry_s), .busy(busy_s)
    );

    typedef struct {
        logic [3:0] req;
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       carry;
        logic [7:0] sat_sum;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        op_a[i*8 +: 8] = a;
        op_b[i*8 +: 8] = b;
    endtask

    // Ticks until res_valid or the bound expires; checks latency and which requester got acked.
    task automatic wait_ack(input string name, input int exp_id, input int exp_lat);
        int lat;
        logic [3:0] exp_ack;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!res_valid && lat < 12);
        exp_ack = 4'b0001 << exp_id;
        check({name, "_valid"}, 32'(res_valid), 32'd1);
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_ack"}, 32'(ack), 32'(exp_ack));
        check({name, "_id"}, 32'(res_id), 32'(exp_id));
        check({name, "_sat_ack"}, 32'(ack_s), 32'(exp_ack));
    endtask

    initial begin
        int ack_ids[5];
        int ack_cyc[5];
        int n_ack;
        logic [3:0] pend;

        //        req      id  a     b     sum   c     sat
        vecs[0] = '{4'b0100, 2, 8'd20, 8'd22, 8'd42, 1'b0, 8'd42};
        vecs[1] = '{4'b0001, 0, 8'd200, 8'd100, 8'd44, 1'b1, 8'd255};
        vecs[2] = '{4'b0010, 1, 8'd255, 8'd1, 8'd0, 1'b1, 8'd255};
        vecs[3] = '{4'b1000, 3, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0};
        vecs[4] = '{4'b1000, 3, 8'd128, 8'd127, 8'd255, 1'b0, 8'd255};
        vecs[5] = '{4'b0001, 0, 8'd255, 8'd255, 8'd254, 1'b1, 8'd255};

        // Reset with all requests pending
        rst  = 1'b1;
        req  = 4'b1111;
        for (int i = 0; i < 4; i++) set_op(i, 8'(10*i + 1), 8'(i + 3));
        tick();
        tick();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_id", 32'(res_id), 32'd0);
        check("rst_sum", 32'(res_sum), 32'd0);
        check("rst_carry", 32'(res_carry), 32'd0);

        // Round robin: each requester drops on its ack and re-raises one cycle later
        rst   = 1'b0;
        pend  = 4'b0000;
        n_ack = 0;
        for (int cyc = 1; cyc <= 30 && n_ack < 5; cyc++) begin
            tick();
            req  = req | pend;
            pend = 4'b0000;
            if (res_valid) begin
                ack_ids[n_ack] = int'(res_id);
                ack_cyc[n_ack] = cyc;
                check("rr_sum", 32'(res_sum), 32'(8'(10*res_id + 1) + 8'(res_id + 3)));
                n_ack++;
                pend = ack;
                req  = req & ~ack;
            end
        end
        check("rr_count", 32'(n_ack), 32'd5);
        if (n_ack == 5) begin
            check("rr_first_lat", 32'(ack_cyc[0]), 32'd2);
            for (int k = 0; k < 5; k++) begin
                check("rr_order", 32'(ack_ids[k]), 32'(k % 4));
                if (k > 0) check("rr_spacing", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd3);
            end
        end
        req  = 4'b0000;
        pend = 4'b0000;
        tick();
        tick();

        // Single-requester vectors, other slices filled with junk to catch slicing errors
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++) set_op(i, 8'h5A, 8'hA5);
            set_op(vecs[v].id, vecs[v].a, vecs[v].b);
            req = vecs[v].req;
            tick();
            check("vec_busy_exec", 32'(busy), 32'd1);
            check("vec_novalid_exec", 32'(res_valid), 32'd0);
            wait_ack("vec", vecs[v].id, 1);
            check("vec_busy_done", 32'(busy), 32'd1);
            check("vec_sum", 32'(res_sum), 32'(vecs[v].sum));
            check("vec_carry", 32'(res_carry), 32'(vecs[v].carry));
            check("vec_sat_sum", 32'(res_sum_s), 32'(vecs[v].sat_sum));
            check("vec_sat_carry", 32'(res_carry_s), 32'(vecs[v].carry));
            req = 4'b0000;
            tick();
            check("vec_idle_valid", 32'(res_valid), 32'd0);
            check("vec_idle_busy", 32'(busy), 32'd0);
        end

        // Drop req and change op_a during EXEC: captured operands still used
        set_op(1, 8'd7, 8'd9);
        req = 4'b0010;
        tick();
        req = 4'b0000;
        set_op(1, 8'd100, 8'd9);
        wait_ack("drop", 1, 1);
        check("drop_sum", 32'(res_sum), 32'd16);
        tick();

        // Reset during EXEC: no ack, pointer returns to 0
        set_op(0, 8'd1, 8'd1);
        req = 4'b0001;
        tick();
        check("rstx_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
        check("rstx_ack", 32'(ack), 32'd0);
        check("rstx_busy", 32'(busy), 32'd0);
        check("rstx_sum", 32'(res_sum), 32'd0);
        tick();
        tick();
        check("rstx_no_late_ack", 32'(ack), 32'd0);
        // rr_ptr was 2 before reset; 4'b1001 goes to 0 only if it was cleared
        set_op(3, 8'd3, 8'd3);
        req = 4'b1001;
        wait_ack("rstx_ptr", 0, 2);
        check("rstx_ptr_sum", 32'(res_sum), 32'd2);
        req = 4'b0000;
        tick();

        // Wrap: serve 2 so rr_ptr=3, then 4'b1001 serves 3 before 0
        set_op(2, 8'd1, 8'd2);
        req = 4'b0100;
        wait_ack("wrap_prime", 2, 2);
        req = 4'b0000;
        tick();
        req = 4'b1001;
        wait_ack("wrap_first", 3, 2);
        check("wrap_first_sum", 32'(res_sum), 32'd6);
        req = 4'b0001;
        wait_ack("wrap_second", 0, 3);
        check("wrap_second_sum", 32'(res_sum), 32'd2);
        req = 4'b0000;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
